// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants, typedefs and grant encoding for the write-back arbiter
package rf_pkg;

    localparam int XLEN_C  = 32;
    localparam int NREGS_C = 32;

    typedef logic [4:0]        reg_addr_t;
    typedef logic [XLEN_C-1:0] word_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-back request bundle for pipeline (A) and long-latency (B) ports
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32
);
    import rf_pkg::*;

    logic             a_valid;
    logic             a_ready;
    reg_addr_t        a_rd;
    logic [XLEN-1:0]  a_data;

    logic             b_valid;
    logic             b_ready;
    reg_addr_t        b_rd;
    logic [XLEN-1:0]  b_data;

    // Requesters drive valid/payload and watch ready.
    modport master (
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready
    );

    // The arbiter consumes requests and returns ready.
    modport slave (
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rtl/rf_wb_arbiter_scoreboard.sv - pending long-latency destination bits with set/clear/flush and two query ports
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_C
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      issue_set,
    input  reg_addr_t issue_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  logic      flush,
    input  reg_addr_t query_rs1,
    input  reg_addr_t query_rs2,
    output logic      busy_rs1,
    output logic      busy_rs2
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    // Flush or clear first, then the issue set so a same-cycle set on the cleared rd survives.
    always_comb begin
        sb_d = sb_q;
        if (flush) begin
            sb_d = '0;
        end else if (clr_en) begin
            sb_d[clr_rd] = 1'b0;
        end
        if (issue_set && (issue_rd != '0)) begin
            sb_d[issue_rd] = 1'b1;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Queries see pre-edge state only; x0 is never reported busy.
    assign busy_rs1 = (query_rs1 != '0) && sb_q[query_rs1];
    assign busy_rs2 = (query_rs2 != '0) && sb_q[query_rs2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with starvation guard and write stage (optional RF_ARB_BYPASS_EN)
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN         = XLEN_C,
    parameter int NREGS        = NREGS_C,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    rf_wb_arbiter_if.slave    wb,
    input  logic              issue_set,
    input  reg_addr_t         issue_rd,
    input  logic              flush,
    input  reg_addr_t         query_rs1,
    input  reg_addr_t         query_rs2,
    output logic              busy_rs1,
    output logic              busy_rs2,
`ifdef RF_ARB_BYPASS_EN
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output logic              rf_we,
    output reg_addr_t         rf_addr,
    output logic [XLEN-1:0]   rf_wdata
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0]      starve_q;
    logic [3:0]      starve_d;
    grant_t          grant;
    logic            b_forced;
    logic            rf_we_q;
    reg_addr_t       rf_addr_q;
    logic [XLEN-1:0] rf_wdata_q;

    assign b_forced = wb.b_valid && (starve_q == LIMIT_C);

    // A wins by default; B wins when alone or once it has lost LIMIT cycles in a row.
    always_comb begin
        grant = GNT_NONE;
        if (wb.b_valid && (!wb.a_valid || b_forced)) begin
            grant = GNT_B;
        end else if (wb.a_valid) begin
            grant = GNT_A;
        end
    end

    assign wb.a_ready = !b_forced;
    assign wb.b_ready = (grant == GNT_B);

    // Count consecutive B losses; any break in B's wait restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (flush || !wb.b_valid || (grant == GNT_B)) begin
            starve_d = '0;
        end else if (starve_q != LIMIT_C) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Write stage: load on a transfer, x0 writes complete with the enable held low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            case (grant)
                GNT_A: begin
                    rf_we_q    <= (wb.a_rd != '0);
                    rf_addr_q  <= wb.a_rd;
                    rf_wdata_q <= wb.a_data;
                end
                GNT_B: begin
                    rf_we_q    <= (wb.b_rd != '0);
                    rf_addr_q  <= wb.b_rd;
                    rf_wdata_q <= wb.b_data;
                end
                default: rf_we_q <= 1'b0;
            endcase
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue_set (issue_set),
        .issue_rd  (issue_rd),
        .clr_en    (grant == GNT_B),
        .clr_rd    (wb.b_rd),
        .flush     (flush),
        .query_rs1 (query_rs1),
        .query_rs2 (query_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2)
    );

`ifdef RF_ARB_BYPASS_EN
    assign fwd_hit1 = rf_we_q && (rf_addr_q == query_rs1);
    assign fwd_hit2 = rf_we_q && (rf_addr_q == query_rs2);
    assign fwd_data = rf_wdata_q;
`endif

    // A stalled requester must keep its request and payload unchanged.
    assert property (@(posedge clk) disable iff (reset)
        (wb.a_valid && !wb.a_ready) |=> (wb.a_valid && $stable(wb.a_rd) && $stable(wb.a_data)));
    assert property (@(posedge clk) disable iff (reset)
        (wb.b_valid && !wb.b_ready) |=> (wb.b_valid && $stable(wb.b_rd) && $stable(wb.b_data)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench with directed scenarios and randomized traffic against a reference model
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        issue_set;
    reg_addr_t   issue_rd;
    logic        flush;
    reg_addr_t   query_rs1;
    reg_addr_t   query_rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        rf_we;
    reg_addr_t   rf_addr;
    logic [31:0] rf_wdata;
`ifdef RF_ARB_BYPASS_EN
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data;
`endif

    rf_wb_arbiter_if #(.XLEN(32)) wb ();

    rf_wb_arbiter #(.XLEN(32), .NREGS(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (wb),
        .issue_set (issue_set),
        .issue_rd  (issue_rd),
        .flush     (flush),
        .query_rs1 (query_rs1),
        .query_rs2 (query_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
`ifdef RF_ARB_BYPASS_EN
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data  (fwd_data),
`endif
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;

    // Reference state: pending set, B's consecutive-loss count, last write-stage contents.
    bit          m_sb[32];
    int          m_wait;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    logic o_ar, o_br, o_b1, o_b2, o_ga;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-stage monitor: each cycle's predicted outcome is visible just after the following edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("rf_we", {31'd0, rf_we}, {31'd0, mon_e.we});
            chk("rf_addr", {27'd0, rf_addr}, {27'd0, mon_e.addr});
            chk("rf_wdata", rf_wdata, mon_e.data);
        end
    end

    task automatic cycle(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                         input logic iss, input logic [4:0] ird, input logic fl,
                         input logic [4:0] qa, input logic [4:0] qb);
        bit  bw;
        bit  aw;
        wr_t e;
        @(negedge clk);
        reset      = rst;
        wb.a_valid = av;  wb.a_rd = ard;  wb.a_data = adat;
        wb.b_valid = bv;  wb.b_rd = brd;  wb.b_data = bdat;
        issue_set  = iss; issue_rd = ird; flush = fl;
        query_rs1  = qa;  query_rs2 = qb;
        #1;
        o_ar = wb.a_ready; o_br = wb.b_ready; o_b1 = busy_rs1; o_b2 = busy_rs2;
        bw   = bv && (!av || m_wait == LIMIT);
        aw   = av && !bw;
        o_ga = aw;
        if (av) chk("a_ready", {31'd0, o_ar}, {31'd0, aw});
        chk("b_ready", {31'd0, o_br}, {31'd0, bw});
        chk("busy_rs1", {31'd0, o_b1}, {31'd0, m_sb[qa]});
        chk("busy_rs2", {31'd0, o_b2}, {31'd0, m_sb[qb]});
`ifdef RF_ARB_BYPASS_EN
        chk("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, m_we && (m_addr == qa)});
        chk("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, m_we && (m_addr == qb)});
        if (m_we) chk("fwd_data", fwd_data, m_data);
`endif
        if (rst) begin
            e = '{1'b0, 5'd0, 32'd0};
            foreach (m_sb[i]) m_sb[i] = 1'b0;
            m_wait = 0;
        end else begin
            if (aw)      e = '{ard != 5'd0, ard, adat};
            else if (bw) e = '{brd != 5'd0, brd, bdat};
            else         e = '{1'b0, m_addr, m_data};
            if (!bv || bw || fl) m_wait = 0;
            else if (m_wait < LIMIT) m_wait++;
            if (fl) foreach (m_sb[i]) m_sb[i] = 1'b0;
            if (bw) m_sb[brd] = 1'b0;
            if (iss && ird != 5'd0) m_sb[ird] = 1'b1;
        end
        exp_q.push_back(e);
        m_we = e.we; m_addr = e.addr; m_data = e.data;
    endtask

    task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, qa, qb);
    endtask

    logic [10:0] pat_br;
    logic        a_p, b_p, rst_r, iss_r, fl_r;
    logic [4:0]  a_rd_r, b_rd_r, ird_r, qa_r, qb_r;
    logic [31:0] a_dat_r, b_dat_r;

    initial begin
        reset = 1'b1; issue_set = 0; issue_rd = 0; flush = 0; query_rs1 = 0; query_rs2 = 0;
        wb.a_valid = 0; wb.a_rd = 0; wb.a_data = 0;
        wb.b_valid = 0; wb.b_rd = 0; wb.b_data = 0;
        foreach (m_sb[i]) m_sb[i] = 1'b0;
        m_wait = 0; m_we = 0; m_addr = 0; m_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_rf_addr", {27'd0, rf_addr}, 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_a_ready", {31'd0, wb.a_ready}, 32'd1);
        chk("reset_b_ready", {31'd0, wb.b_ready}, 32'd0);

        // Single A write and its one-cycle write-enable pulse.
        cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        chk("a5_we", {31'd0, rf_we}, 32'd1);
        chk("a5_addr", {27'd0, rf_addr}, 32'd5);
        chk("a5_data", rf_wdata, 32'hDEADBEEF);
        idle(0, 0);
        chk("a5_we_drop", {31'd0, rf_we}, 32'd0);

        // Both valid: B forced in after LIMIT losses, twice in a row.
        pat_br = 11'b01000010000;
        for (int i = 0; i < 11; i++) begin
            cycle(0, 1, 5'd1, 32'h11, i < 10, 5'd3, 32'hB0B, 0, 0, 0, 0, 0);
            chk("starve_b_ready", {31'd0, o_br}, {31'd0, pat_br[i]});
            chk("starve_a_ready", {31'd0, o_ar}, {31'd0, !pat_br[i]});
        end

        // Scoreboard set, clear, and set-beats-clear.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 0);
        chk("sb7_same_cycle", {31'd0, o_b1}, 32'd0);
        idle(5'd7, 0);
        chk("sb7_set", {31'd0, o_b1}, 32'd1);
        cycle(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 0, 5'd7, 0);
        idle(5'd7, 0);
        chk("sb7_clear", {31'd0, o_b1}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 5'd7, 32'h78, 1, 5'd7, 0, 5'd7, 0);
        idle(5'd7, 0);
        chk("sb7_set_wins", {31'd0, o_b1}, 32'd1);
        cycle(0, 0, 0, 0, 1, 5'd7, 32'h79, 0, 0, 0, 0, 0);

        // x0 write accepted without enable; x0 never busy.
        cycle(0, 1, 5'd0, 32'h1234, 0, 0, 0, 1, 5'd0, 0, 0, 0);
        idle(0, 0);
        chk("x0_we", {31'd0, rf_we}, 32'd0);
        chk("x0_data", rf_wdata, 32'h1234);
        chk("x0_busy", {31'd0, o_b1}, 32'd0);

        // Flush together with an issue keeps only the new destination.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 1, 5'd3, 5'd9);
        chk("pre_flush_3", {31'd0, o_b1}, 32'd1);
        idle(5'd3, 5'd9);
        chk("flush_3", {31'd0, o_b1}, 32'd0);
        chk("flush_9", {31'd0, o_b2}, 32'd0);
        idle(5'd12, 5'd12);
        chk("flush_12", {31'd0, o_b1}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

`ifdef RF_ARB_BYPASS_EN
        cycle(0, 1, 5'd4, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0, 5'd4);
        idle(0, 5'd4);
        chk("byp_hit2", {31'd0, fwd_hit2}, 32'd1);
        chk("byp_data", fwd_data, 32'hCAFE);
        idle(0, 5'd4);
        chk("byp_hit2_drop", {31'd0, fwd_hit2}, 32'd0);
`endif

        // Reset while the write stage is busy discards the reset-cycle transfer.
        cycle(0, 1, 5'd6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 5'd8, 32'h88, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_we_before", {31'd0, rf_we}, 32'd1);
        idle(0, 0);
        chk("rst_we_after", {31'd0, rf_we}, 32'd0);

        // Randomized traffic; requests hold until granted.
        a_p = 0; b_p = 0;
        a_rd_r = 0; b_rd_r = 0; a_dat_r = 0; b_dat_r = 0;
        for (int n = 0; n < 400; n++) begin
            if (!a_p && $urandom_range(0, 1) == 1) begin
                a_p = 1; a_rd_r = 5'($urandom); a_dat_r = $urandom;
            end
            if (!b_p && $urandom_range(0, 2) == 0) begin
                b_p = 1; b_rd_r = 5'($urandom); b_dat_r = $urandom;
            end
            rst_r = ($urandom_range(0, 99) == 0);
            iss_r = ($urandom_range(0, 2) == 0);
            fl_r  = ($urandom_range(0, 49) == 0);
            ird_r = 5'($urandom);
            qa_r  = 5'($urandom);
            qb_r  = 5'($urandom);
            cycle(rst_r, a_p, a_rd_r, a_dat_r, b_p, b_rd_r, b_dat_r, iss_r, ird_r, fl_r, qa_r, qb_r);
            if (!rst_r && o_ga) a_p = 0;
            if (!rst_r && o_br && b_p && !o_ga) b_p = 0;
        end

        idle(0, 0);
        @(posedge clk);
        #2;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard in front of the three-ported register file's single write port. It shares that port between the in-order pipeline write-back (port A) and the long-latency unit (port B: loads, mul/div) using valid/ready handshakes, and drives the file's write enable, address and data from a registered stage. A 32-bit scoreboard tracks destination registers owned by outstanding long-latency ops so issue logic can stall on RAW/WAW hazards.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural registers; address width is $clog2(NREGS)
- STARVE_LIMIT, 4, consecutive cycles B may lose before it is forced to win; range 1..15
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- a_valid / a_ready  in / out  1 / 1  pipeline write-back handshake
- a_rd / a_data  in  5 / XLEN  destination and value for port A
- b_valid / b_ready  in / out  1 / 1  long-latency write-back handshake
- b_rd / b_data  in  5 / XLEN  destination and value for port B
- issue_set / issue_rd  in  1 / 5  a long-latency op with destination issue_rd is issued this cycle
- flush  in  1  clears the scoreboard and the starvation counter
- query_rs1 / query_rs2  in  5 / 5  issue-stage source registers
- busy_rs1 / busy_rs2  out  1 / 1  combinational: the queried register has a pending B write
- rf_we / rf_addr / rf_wdata  out  1 / 5 / XLEN  registered write to the register file
- fwd_hit1 / fwd_hit2 / fwd_data  out  1 / 1 / XLEN  bypass outputs; present only with RF_ARB_BYPASS_EN

## Operation
- A transfer occurs on any cycle where valid && ready are both high. At most one transfer per cycle. Grants are combinational from the valids and the counter.
- Priority: A wins by default. If starve_cnt == STARVE_LIMIT and b_valid, B wins and a_ready = 0.
- A single valid requester is always granted.
- starve_cnt increments when b_valid && !b_ready. It saturates at STARVE_LIMIT. It clears on a B transfer, on !b_valid, on flush, and on reset.
- A transfer loads the write stage: rf_we <= (rd != 0), rf_addr <= rd, rf_wdata <= data.
  - Writes to x0 are accepted and completed, but rf_we stays 0.
  - With no transfer, rf_we <= 0. rf_addr and rf_wdata hold their values.
- Scoreboard sb[NREGS-1:0]:
  - issue_set sets sb[issue_rd] when issue_rd != 0.
  - A B transfer clears sb[b_rd].
  - issue_set and a B clear on the same rd in the same cycle: set wins.
  - A transfers never touch the scoreboard.
  - flush clears every bit, then applies that cycle's issue_set.
- busy_rsN = sb[query_rsN]. It is always 0 for register 0. It reflects state before the current edge, so there is no same-cycle bypass of issue_set.
- Requesters must hold valid and payload stable until ready. This is not checked, except by an assertion.

## Timing
- Reset values:
  - rf_we = 0, rf_addr = 0, rf_wdata = 0
  - sb = 0, starve_cnt = 0
  - a_ready = 1, b_ready = 0 (unless b_valid && !a_valid)
  - busy = 0, fwd_hit = 0
- Latency: a transfer on cycle N gives rf_we high during N+1. The register file commits at the end of N+1, and the value is readable on N+2.
- Reset asserted while rf_we is high: rf_we is 0 on the next cycle. A transfer in the reset cycle is discarded.
- Throughput: one write per cycle, sustained.
- Starvation: with A valid continuously, B waits at most STARVE_LIMIT cycles before it wins.

## Configuration
- RF_ARB_BYPASS_EN defined:
  - fwd_hitN = rf_we && (rf_addr == query_rsN).
  - fwd_data = rf_wdata.
  - Issue logic uses these to take a value in the cycle it is being written.
- RF_ARB_BYPASS_EN undefined:
  - The fwd_* ports are absent.
  - Consumers must wait one extra cycle after rf_we.
- Arbitration and scoreboard behaviour are identical in both builds.

## Structure
- Package rf_pkg holds:
  - XLEN_C and NREGS_C constants
  - reg_addr_t (logic [4:0]) and word_t (logic [XLEN-1:0]) typedefs
  - typedef enum {GNT_NONE, GNT_A, GNT_B} grant_t
- Sub-module rf_scoreboard contains the sb vector, the set/clear/flush logic and both query ports. The arbiter, starvation counter and write stage stay in rf_wb_arbiter.

## Test plan
- Reset then a_valid, a_rd=5, a_data=32'hDEADBEEF -> a_ready=1; next cycle rf_we=1, rf_addr=5, rf_wdata=32'hDEADBEEF; the cycle after, rf_we=0.
- a_valid and b_valid held high with STARVE_LIMIT=4 -> A wins 4 cycles, B wins the 5th (b_ready=1, a_ready=0), starve_cnt returns to 0, A wins again.
- issue_set with rd=7 -> busy for query 7 = 1 from the next cycle; B writes rd=7 -> busy = 0 the cycle after; issue_set rd=7 in the same cycle as the B clear of 7 -> busy stays 1.
- a_rd=0 with data 32'h1234 -> accepted, rf_we stays 0; issue_set rd=0 -> busy for query 0 stays 0.
- Set sb bits 3 and 9, pulse flush together with issue_set rd=12 -> only busy for register 12 = 1.
- Bypass build: A writes rd=4 = 32'hCAFE with query_rs2=4 -> fwd_hit2=1 and fwd_data=32'hCAFE during the rf_we cycle, fwd_hit2=0 the next cycle.
